data_memory: RTL
================

// Module: data_memory
// PURPOSE
//  Parametrised data memory for the datapath MEM stage; next generation of the word-only block RAM.
//  Byte-addressed, little-endian, with byte/half/full-width loads and stores and sign or zero extension.
//  Adds a second, read-only debug port for the debug unit's memory dump.
//  Adds a hardware clear/initialise sweep, run after reset or on request, with a busy flag.
// PARAMETERS
//  ADDRESS_BITS  8   word-address width; MEM_SIZE = 2**ADDRESS_BITS words
//  DATA_BITS     32  word width; must be a power of two and >= 16
//  INIT_MODE     1   sweep pattern: 0 = all zeros, 1 = mem[i] = i (zero-extended word index)
//  Derived: OFF_BITS = log2(DATA_BITS/8); byte address width BA = ADDRESS_BITS + OFF_BITS
// PORTS
//  clk            in   1          clock; all state changes on posedge
//  rst            in   1          asynchronous, active-low reset
//  i_read_enable  in   1          load request this cycle
//  i_write_enable in   1          store request this cycle
//  i_address      in   BA         byte address; [OFF_BITS-1:0] = byte offset within the word
//  i_data         in   DATA_BITS  store data, right-aligned (byte in [7:0], half in [15:0])
//  i_size         in   2          00 byte, 01 half (16 b), 10 full word, 11 reserved (treated as misaligned)
//  i_unsigned     in   1          1: zero-extend loads; 0: sign-extend loads
//  i_clear        in   1          start an initialise sweep (accepted in IDLE only)
//  i_dbg_address  in   ADDRESS_BITS  debug word address
//  o_data         out  DATA_BITS  load result, extended to DATA_BITS
//  o_misaligned   out  1          misaligned/reserved access flag for the previous request
//  o_dbg_data     out  DATA_BITS  raw word at i_dbg_address
//  o_busy         out  1          1 while a sweep is running
// BEHAVIOUR
//  Reset (rst=0, asynchronous): o_data=0, o_dbg_data=0, o_misaligned=0, sweep counter=0, state=CLEAR, o_busy=1.
//   Array contents are not reset directly; the sweep rewrites them.
//  FSM states: CLEAR, IDLE.
//   CLEAR: writes the INIT_MODE pattern to mem[cnt] on each posedge; cnt++.
//   CLEAR: after writing cnt = MEM_SIZE-1, next state IDLE, o_busy=0. Sweep takes exactly MEM_SIZE cycles.
//   CLEAR: read/write/clear requests are ignored; o_data and o_misaligned are held at 0.
//   IDLE: i_clear=1 -> CLEAR with cnt=0, o_busy=1 from the next cycle. A store in the same cycle as i_clear is still performed.
//   Reset asserted mid-sweep restarts the sweep from word 0.
//  Alignment: byte = any offset; half = offset[0]==0; full = offset==0; i_size=11 is always misaligned.
//  Misaligned request (read or write): o_misaligned=1 on the next cycle and the store is suppressed.
//   A misaligned load gives o_data=0.
//   o_misaligned=0 after any aligned or idle cycle.
//  Store: 1-cycle write at posedge; only the addressed byte lanes are updated, other lanes are kept.
//   Byte k of the word = bits [8k+7:8k]. Lane index = offset (byte) or offset..offset+1 (half).
//  Load: synchronous, 1-cycle latency.
//   o_data is updated at the posedge after the request; the lane is extracted by offset and size, then extended per i_unsigned.
//   Full-word loads ignore i_unsigned.
//   o_data holds its value when i_read_enable=0.
//  Read and write in the same cycle, same word: read-first; the load returns pre-store contents.
//  Debug port: always active, including during a sweep. o_dbg_data <= mem[i_dbg_address] every posedge, 1-cycle latency, read-first.
//  Address wrap: none needed; i_address covers exactly MEM_SIZE words.
// TESTING
//  T1 Release reset, wait MEM_SIZE cycles (INIT_MODE=1) -> o_busy falls on cycle 256; dbg read of word 0x05 -> 0x00000005.
//  T2 IDLE: sw 0x8899AABB at byte addr 0x10; lb addr 0x11, i_unsigned=0 -> o_data=0xFFFFFFAA; lbu 0x11 -> 0x000000AA.
//  T3 sb 0x5A to addr 0x12 over 0x8899AABB; lw 0x10 -> 0x885AAABB; lh 0x12 signed -> 0xFFFF885A.
//  T4 sh to addr 0x13 and lw at 0x02 -> o_misaligned=1, o_data=0; word 0x04 is unchanged (check via dbg port).
//  T5 Same-cycle sw 0x11111111 and lw at addr 0x20 holding 0x22222222 -> o_data=0x22222222; next lw -> 0x11111111.
//  T6 i_clear, then assert rst at cycle 100 of the sweep -> o_busy stays 1 and the sweep restarts at 0; a store during busy is lost.

Source files
------------

// File: rtl/data_memory.sv
// data_memory: byte-addressed, little-endian data memory for the MEM stage.
// Supports byte/half/word loads and stores with sign or zero extension, a
// read-only debug port, and a hardware initialise sweep after reset or on
// request. All state changes happen on the rising clock edge; the reset is
// asynchronous and active-low.
module data_memory #(
    parameter int ADDRESS_BITS = 8,
    parameter int DATA_BITS    = 32,
    parameter int INIT_MODE    = 1,
    localparam int OFF_BITS    = $clog2(DATA_BITS / 8),
    localparam int BA          = ADDRESS_BITS + OFF_BITS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_read_enable,
    input  logic                    i_write_enable,
    input  logic [BA-1:0]           i_address,
    input  logic [DATA_BITS-1:0]    i_data,
    input  logic [1:0]              i_size,
    input  logic                    i_unsigned,
    input  logic                    i_clear,
    input  logic [ADDRESS_BITS-1:0] i_dbg_address,
    output logic [DATA_BITS-1:0]    o_data,
    output logic                    o_misaligned,
    output logic [DATA_BITS-1:0]    o_dbg_data,
    output logic                    o_busy
);

    localparam int MEM_SIZE   = 2 ** ADDRESS_BITS;
    localparam int LANES      = DATA_BITS / 8;
    localparam int SHIFT_BITS = OFF_BITS + 3;

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDRESS_BITS-1:0] cnt_q, cnt_d;

    logic [DATA_BITS-1:0]    mem [MEM_SIZE];

    logic [ADDRESS_BITS-1:0] word_addr;
    logic [OFF_BITS-1:0]     offset;
    logic [SHIFT_BITS-1:0]   shamt;
    logic                    aligned;
    logic [LANES-1:0]        lane_en;
    logic [DATA_BITS-1:0]    rd_word;
    logic [DATA_BITS-1:0]    rd_shifted;
    logic [DATA_BITS-1:0]    wr_shifted;
    logic [DATA_BITS-1:0]    load_value;
    logic [DATA_BITS-1:0]    init_word;
    logic                    idle;
    logic                    bad_access;
    logic                    do_store;
    logic                    do_load;

    // Split the byte address into a word index and a lane offset; both the
    // load and store data are moved between lane 0 and the addressed lane
    // with a shift of offset*8 bits.
    assign word_addr  = i_address[BA-1:OFF_BITS];
    assign offset     = i_address[OFF_BITS-1:0];
    assign shamt      = {offset, 3'b000};
    assign rd_word    = mem[word_addr];
    assign rd_shifted = rd_word >> shamt;
    assign wr_shifted = i_data << shamt;

    // The sweep pattern is either all zeros or the word's own index.
    assign init_word  = (INIT_MODE == 1) ? DATA_BITS'(cnt_q) : '0;

    assign idle       = (state_q == IDLE);
    assign bad_access = (i_read_enable | i_write_enable) & ~aligned;
    assign do_store   = idle & i_write_enable & aligned;
    assign do_load    = idle & i_read_enable;
    assign o_busy     = (state_q == CLEAR);

    // Decide whether the access fits its natural alignment and which byte
    // lanes a store would touch; the reserved size code never aligns.
    always_comb begin
        aligned = 1'b0;
        lane_en = '0;
        case (i_size)
            2'b00: begin
                aligned = 1'b1;
                lane_en = LANES'(1) << offset;
            end
            2'b01: begin
                aligned = ~offset[0];
                lane_en = LANES'(3) << offset;
            end
            2'b10: begin
                aligned = (offset == '0);
                lane_en = '1;
            end
            default: begin
                aligned = 1'b0;
                lane_en = '0;
            end
        endcase
    end

    // Extract the addressed lane and extend it to a full word; a word load
    // is already right-aligned because its offset is zero.
    always_comb begin
        load_value = rd_shifted;
        case (i_size)
            2'b00: load_value = i_unsigned ? DATA_BITS'(rd_shifted[7:0])
                                           : DATA_BITS'($signed(rd_shifted[7:0]));
            2'b01: load_value = i_unsigned ? DATA_BITS'(rd_shifted[15:0])
                                           : DATA_BITS'($signed(rd_shifted[15:0]));
            default: load_value = rd_shifted;
        endcase
    end

    // State and sweep counter registers; reset always restarts the sweep.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Sweep walks every word once and drops to IDLE after the last one;
    // IDLE only leaves on a clear request.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CLEAR: begin
                if (cnt_q == {ADDRESS_BITS{1'b1}}) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            IDLE: begin
                if (i_clear) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // Array write port: the sweep owns it while busy, otherwise aligned
    // stores update only their own byte lanes.
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            mem[cnt_q] <= init_word;
        end else if (do_store) begin
            for (int k = 0; k < LANES; k++) begin
                if (lane_en[k]) begin
                    mem[word_addr][8*k +: 8] <= wr_shifted[8*k +: 8];
                end
            end
        end
    end

    // Registered load, misalignment flag and debug outputs; loads and the
    // debug read see the array contents from before this edge's store.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_data       <= '0;
            o_misaligned <= 1'b0;
            o_dbg_data   <= '0;
        end else begin
            o_dbg_data <= mem[i_dbg_address];
            if (!idle) begin
                o_data       <= '0;
                o_misaligned <= 1'b0;
            end else begin
                o_misaligned <= bad_access;
                if (do_load) begin
                    o_data <= aligned ? load_value : '0;
                end
            end
        end
    end

endmodule
